// File: rtl/pc_gen_if.sv
// Fetch-address interface between the PC generator and the fetch/control side.
// The control side holds the master modport and pc_gen holds the slave modport.
interface pc_gen_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 stall;
  logic                 redirect_valid;
  logic [WIDTH-1:0]     redirect_target;
  logic                 trap_req;
  logic                 halt_req;
  logic                 resume;
  logic                 fetch_ready;
  logic [WIDTH-1:0]     pc_out;
  logic                 pc_valid;
  logic                 misalign;
  logic [WIDTH-1:0]     misalign_addr;
  logic [CNT_WIDTH-1:0] fetch_cnt;

  modport master (
    output stall, redirect_valid, redirect_target, trap_req, halt_req, resume, fetch_ready,
    input  pc_out, pc_valid, misalign, misalign_addr, fetch_cnt
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_req, halt_req, resume, fetch_ready,
    output pc_out, pc_valid, misalign, misalign_addr, fetch_cnt
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-address generator: holds the PC and picks the next one from trap, redirect or increment.
// All outputs are registered; BOOT/RUN/HALT sequencing lives in one clocked process.
module pc_gen #(
  parameter int              WIDTH      = 32,
  parameter longint unsigned RESET_VEC  = 64'h0,
  parameter longint unsigned TRAP_VEC   = 64'h100,
  parameter int              IMEM_WORDS = 64,
  parameter int              CNT_WIDTH  = 32
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  pc_if
);

  localparam logic [WIDTH-1:0] AMASK    = WIDTH'(longint'(IMEM_WORDS) * 4 - 1);
  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC) & AMASK;
  localparam logic [WIDTH-1:0] TRAP_PC  = WIDTH'(TRAP_VEC) & AMASK;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_pc;
  logic                 r_pc_valid;
  logic                 r_misalign;
  logic [WIDTH-1:0]     r_misalign_addr;
  logic [CNT_WIDTH-1:0] r_fetch_cnt;

  logic w_acc;
  logic w_bad_target;

  assign w_acc        = r_pc_valid & pc_if.fetch_ready & ~pc_if.stall;
  assign w_bad_target = pc_if.redirect_target[1:0] != 2'b00;

  // NOTE: every register here updates with <= so all of them see the same pre-edge values;
  // rst is tested first so it overrides HALT, redirect and trap alike.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_BOOT;
      r_pc            <= '0;
      r_pc_valid      <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
      r_fetch_cnt     <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (w_acc) r_fetch_cnt <= r_fetch_cnt + CNT_WIDTH'(1);

      case (r_state)
        S_BOOT: begin
          r_state    <= S_RUN;
          r_pc       <= RESET_PC;
          r_pc_valid <= 1'b1;
        end

        S_RUN: begin
          if (pc_if.trap_req) begin
            r_pc <= TRAP_PC;
          end else if (pc_if.redirect_valid && w_bad_target) begin
            r_pc            <= TRAP_PC;
            r_misalign      <= 1'b1;
            r_misalign_addr <= pc_if.redirect_target;
          end else if (pc_if.redirect_valid) begin
            // Redirects bypass stall/fetch_ready: a taken branch must not be lost.
            r_pc <= pc_if.redirect_target & AMASK;
          end else if (w_acc) begin
            r_pc <= (r_pc + WIDTH'(4)) & AMASK;
          end
          if (pc_if.halt_req) begin
            r_state    <= S_HALT;
            r_pc_valid <= 1'b0;
          end
        end

        S_HALT: begin
          if (pc_if.trap_req) begin
            r_state    <= S_RUN;
            r_pc       <= TRAP_PC;
            r_pc_valid <= 1'b1;
          end else if (pc_if.resume && !pc_if.halt_req) begin
            r_state    <= S_RUN;
            r_pc_valid <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_BOOT;
          r_pc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc_if.pc_out        = r_pc;
  assign pc_if.pc_valid      = r_pc_valid;
  assign pc_if.misalign      = r_misalign;
  assign pc_if.misalign_addr = r_misalign_addr;
  assign pc_if.fetch_cnt     = r_fetch_cnt;

endmodule
